// File: rtl/deemphasis_pkg.sv
// Shared types and coefficient constants for the multichannel FM de-emphasis filter.
package deemphasis_pkg;

  typedef enum logic [1:0] {
    MODE_50US   = 2'd0,
    MODE_75US   = 2'd1,
    MODE_BYPASS = 2'd2
  } mode_t;

  localparam longint TAU_50US_NS = 64'sd50000;
  localparam longint TAU_75US_NS = 64'sd75000;
  localparam longint FS_HZ       = 64'sd32000;

  // b = 1 - exp(-1/(tau*fs)) scaled by 2^(coef_width-1), rounded to nearest.
  // exp() is evaluated as a Q30 Taylor series in integer arithmetic, so the
  // constant elaborates with no real-typed objects anywhere.
  function automatic longint deemph_coef(input longint tau_ns, input longint fs_hz,
                                         input int coef_width);
    longint one_q, den, a_q, term, acc;
    one_q = 64'sd1 << 30;
    den   = tau_ns * fs_hz;
    a_q   = ((one_q * 64'sd1000000000) + (den >>> 1)) / den;
    term  = one_q;
    acc   = one_q;
    for (int k = 1; k <= 24; k++) begin
      term = -((term * a_q) / one_q) / longint'(k);
      acc  = acc + term;
    end
    return (((one_q - acc) << (coef_width - 1)) + (one_q >>> 1)) >>> 30;
  endfunction

endpackage

// File: rtl/deemphasis_mac.sv
// Shared subtract-multiply-round-saturate datapath: y + b*(x<<guard - y).
// Stage 1 registers the product; stage 2 rounds and saturates combinationally
// so the caller can write the channel state on the following edge.
module deemphasis_mac #(
  parameter int width      = 16,
  parameter int guard      = 4,
  parameter int coef_width = 18,
  parameter int idx_w      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     issue,
  input  logic [idx_w-1:0]         issue_ch,
  input  logic [width-1:0]         x,
  input  logic [width+guard-1:0]   y,
  input  logic [coef_width-1:0]    b,
  input  logic                     bypass,
  output logic                     res_vld,
  output logic [idx_w-1:0]         res_ch,
  output logic [width+guard-1:0]   res_y
);
  localparam int W  = width + guard;
  localparam int PW = W + coef_width + 2;

  localparam logic signed [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (coef_width - 2);
  localparam logic signed [PW-1:0] YMAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] YMIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [W-1:0]  xa;
  logic signed [W:0]    diff;
  logic signed [PW-1:0] prod;

  logic                 vld_q;
  logic [idx_w-1:0]     ch_q;
  logic signed [PW-1:0] prod_q;
  logic signed [W-1:0]  y_q, xa_q;
  logic                 byp_q;

  logic signed [PW-1:0] step, sum;
  logic signed [W-1:0]  sat;

  // Stage 1 operands: left-align x, one extra bit for the difference, unsigned coefficient.
  always_comb begin
    xa   = {x, {guard{1'b0}}};
    diff = {xa[W-1], xa} - {y[W-1], y};
    prod = PW'(diff) * PW'($signed({1'b0, b}));
  end

  // Product register; flush and reset kill the in-flight channel.
  always_ff @(posedge clk) begin
    if (reset || flush) vld_q <= 1'b0;
    else                vld_q <= issue;
    if (issue) begin
      ch_q   <= issue_ch;
      prod_q <= prod;
      y_q    <= $signed(y);
      xa_q   <= xa;
      byp_q  <= bypass;
    end
  end

  // Stage 2: round half-up to the state grid, accumulate, clamp to the state range.
  always_comb begin
    step = (prod_q + HALF) >>> (coef_width - 1);
    sum  = step + PW'(y_q);
    if (sum > YMAX)      sat = YMAX[W-1:0];
    else if (sum < YMIN) sat = YMIN[W-1:0];
    else                 sat = sum[W-1:0];
  end

  assign res_vld = vld_q;
  assign res_ch  = ch_q;
  assign res_y   = byp_q ? xa_q : sat;

endmodule

// File: rtl/deemphasis_mc.sv
// Multichannel first-order de-emphasis: one frame in, channels processed
// serially through one shared MAC, all output lanes updated together.
module deemphasis_mc
  import deemphasis_pkg::*;
#(
  parameter int width      = 16,
  parameter int channels   = 2,
  parameter int guard      = 4,
  parameter int coef_width = 18
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  mode_t                            mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [channels-1:0][width-1:0]   in_data,
  output logic                             out_valid,
  output logic [channels-1:0][width-1:0]   out_data
);
  localparam int W    = width + guard;
  localparam int IDXW = (channels > 1) ? $clog2(channels) : 1;
  localparam int CNTW = $clog2(channels + 1);

  localparam logic [coef_width-1:0] B50 =
    coef_width'(deemph_coef(TAU_50US_NS, FS_HZ, coef_width));
  localparam logic [coef_width-1:0] B75 =
    coef_width'(deemph_coef(TAU_75US_NS, FS_HZ, coef_width));
  localparam logic [W:0] OHALF = {{W{1'b0}}, 1'b1} << (guard - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  state_t state, state_n;

  logic                           busy, accept, issue;
  logic [CNTW-1:0]                cnt;
  logic [IDXW-1:0]                issue_ch;
  logic [channels-1:0][width-1:0] x_q;
  mode_t                          mode_q;
  logic [channels-1:0][W-1:0]     y, y_upd;
  logic [channels-1:0][W:0]       rnd;
  logic [channels-1:0][width-1:0] out_next;
  logic [coef_width-1:0]          b_sel;
  logic                           res_vld, res_last;
  logic [IDXW-1:0]                res_ch;
  logic [W-1:0]                   res_y;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and handshake; clear always wins and drops back to IDLE.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (cnt == CNTW'(channels)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (clear) state_n = S_IDLE;
  end

  assign accept   = in_valid && in_ready && !clear;
  assign issue    = busy && (cnt < CNTW'(channels));
  assign issue_ch = cnt[IDXW-1:0];
  assign b_sel    = (mode_q == MODE_75US) ? B75 : B50;
  assign res_last = res_vld && (res_ch == IDXW'(channels - 1));

  deemphasis_mac #(
    .width      (width),
    .guard      (guard),
    .coef_width (coef_width),
    .idx_w      (IDXW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear),
    .issue    (issue),
    .issue_ch (issue_ch),
    .x        (x_q[issue_ch]),
    .y        (y[issue_ch]),
    .b        (b_sel),
    .bypass   (mode_q == MODE_BYPASS),
    .res_vld  (res_vld),
    .res_ch   (res_ch),
    .res_y    (res_y)
  );

  // State view including the channel finishing this cycle, so the last lane
  // lands in out_data on the same edge as its state update.
  always_comb begin
    y_upd = y;
    if (res_vld) y_upd[res_ch] = res_y;
  end

  // Output lanes: round half-up to width bits; overflow only occurs upward.
  always_comb begin
    rnd      = '0;
    out_next = '0;
    for (int c = 0; c < channels; c++) begin
      rnd[c] = {y_upd[c][W-1], y_upd[c]} + OHALF;
      if (rnd[c][W] == rnd[c][W-1]) out_next[c] = rnd[c][W-1:guard];
      else if (rnd[c][W])           out_next[c] = {1'b1, {(width-1){1'b0}}};
      else                          out_next[c] = {1'b0, {(width-1){1'b1}}};
    end
  end

  // Frame capture, channel sequencing, state write-back and output publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      y         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      x_q       <= '0;
      mode_q    <= MODE_50US;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        y <= '0;
      end else begin
        if (accept) begin
          x_q    <= in_data;
          mode_q <= mode;
          cnt    <= '0;
        end else if (busy) begin
          cnt <= cnt + CNTW'(1);
        end
        if (res_vld) y <= y_upd;
        if (res_last) begin
          out_data  <= out_next;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
